// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF stage. Owns the program counter, fetches one instruction
// at a time over a single-outstanding request/response port, hands it to ID
// over valid/ready, and applies branch (with MIPS delay slot) and exception
// redirects. pc_out doubles as the delay-slot PC seen by ID.
//
// state | meaning
// FETCH | request in flight (or misaligned PC about to report an error)
// HOLD  | instruction valid, waiting for ID to accept it
// DRAIN | flushed by an exception, swallowing the orphaned response
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic        if_addr_err,
    input  logic        id_ready,
    output logic [31:0] pc_out,
    input  logic        is_branch,
    input  logic [31:0] branch_pc,
    input  logic        exc_en,
    input  logic [31:0] exc_pc
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [31:0] target_reg;
    logic        target_pending;
    logic        pc_aligned;
    logic        handoff;
    logic        branch_take;
    logic [31:0] next_pc;

    assign pc_aligned  = (pc_out[1:0] == 2'b00);
    // Gated by reset so the first request appears only once reset is released.
    assign imem_req    = (state == ST_FETCH) && pc_aligned && !reset;
    assign imem_addr   = pc_out;
    assign handoff     = id_ready && if_valid;
    assign branch_take = is_branch && id_ready;

    // Select the PC that follows the instruction being handed to ID.
    always_comb begin
        next_pc = pc_out + 32'd4;
        if (branch_take) begin
            next_pc = branch_pc;
        end else if (target_pending) begin
            next_pc = target_reg;
        end
    end

    // PC, fetch state, IF output register and deferred branch target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_FETCH;
            pc_out         <= RESET_PC;
            if_valid       <= 1'b0;
            if_instr       <= 32'd0;
            if_addr_err    <= 1'b0;
            target_reg     <= 32'd0;
            target_pending <= 1'b0;
        end else if (exc_en) begin
            pc_out         <= exc_pc;
            if_valid       <= 1'b0;
            if_addr_err    <= 1'b0;
            target_pending <= 1'b0;
            // A response still owed by memory must be swallowed before refetching.
            if (state == ST_FETCH && pc_aligned && !imem_rvalid) begin
                state <= ST_DRAIN;
            end else if (state == ST_DRAIN && !imem_rvalid) begin
                state <= ST_DRAIN;
            end else begin
                state <= ST_FETCH;
            end
        end else begin
            // Branch left ID while its delay slot is not yet handed over:
            // remember the target until the delay slot is accepted.
            if (branch_take && !handoff) begin
                target_reg     <= branch_pc;
                target_pending <= 1'b1;
            end
            case (state)
                ST_FETCH: begin
                    if (!pc_aligned) begin
                        if_valid    <= 1'b1;
                        if_addr_err <= 1'b1;
                        if_instr    <= 32'd0;
                        state       <= ST_HOLD;
                    end else if (imem_rvalid) begin
                        if_valid <= 1'b1;
                        if_instr <= imem_rdata;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (handoff) begin
                        pc_out         <= next_pc;
                        if_valid       <= 1'b0;
                        if_addr_err    <= 1'b0;
                        target_pending <= 1'b0;
                        state          <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- IF-stage block that owns the program counter and fetches instructions from instruction memory.
- Fetch uses a single-outstanding, variable-latency request/response interface.
- Hands each instruction to ID through a valid/ready pair.
- Applies the branch/jump redirects that ID resolves, honouring the MIPS delay slot; also applies exception redirects.
- Its pc_out is the delay_slot_pc consumed by ID's branch resolution logic.

Parameters:
RESET_PC, 32'hBFC0_0000, PC value loaded on reset.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request; held high until imem_rvalid.
imem_addr  output  32  word address of the fetch; equals pc_out while imem_req=1.
imem_rvalid  input  1  response strobe, one cycle per request, at least 1 cycle after request.
imem_rdata  input  32  fetched instruction, valid with imem_rvalid.
if_valid  output  1  if_instr/pc_out hold an instruction for ID.
if_instr  output  32  instruction handed to ID.
if_addr_err  output  1  qualifies if_valid: misaligned fetch address; if_instr=0.
id_ready  input  1  ID accepts the IF instruction this cycle; ID's current instruction leaves ID.
pc_out  output  32  PC of the instruction in IF (delay-slot PC when ID holds a branch).
is_branch  input  1  ID redirect request; asserted only for a valid ID instruction.
branch_pc  input  32  redirect target, valid with is_branch.
exc_en  input  1  exception/eret redirect from later stage; highest priority.
exc_pc  input  32  exception/eret target.

Behaviour:
- States: FETCH (request in flight), HOLD (instruction valid, waiting for ID), DRAIN (discarding a response after a flush).
- Reset (any state, any cycle):
  - pc_out=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_addr_err=0, target_pending=0.
  - imem_req rises the cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc_out.
  - If pc_out[1:0]!=0: no request (imem_req=0); next cycle go to HOLD with if_valid=1, if_addr_err=1, if_instr=0.
  - On imem_rvalid: if_instr<=imem_rdata, if_valid<=1, go to HOLD. Fetch-to-valid latency is memory latency +1 register cycle.
- HOLD:
  - if_valid=1; outputs are stable until handoff.
  - Handoff = id_ready & if_valid. On handoff, pc_out <= next_pc, if_valid<=0, if_addr_err<=0, state=FETCH.
- next_pc priority:
  1. branch_pc if is_branch & id_ready this cycle.
  2. Else target_reg if target_pending (then clear target_pending).
  3. Else pc_out+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
- Delay slot: is_branch is sampled only when id_ready=1.
  - If no handoff occurs that cycle (state FETCH), the branch has left ID but its delay slot is still being fetched. Capture target_reg<=branch_pc, target_pending<=1.
  - The delay slot is still delivered; its handoff loads target_reg.
  - The delay-slot instruction is never squashed by is_branch.
- A second is_branch while target_pending=1 overwrites target_reg. Not expected from a legal program; the last value wins.
- Exception: exc_en overrides everything (except reset) in the same cycle.
  - pc_out<=exc_pc, if_valid<=0, if_addr_err<=0, target_pending<=0.
  - If state=FETCH with a request outstanding and imem_rvalid not present this cycle: go to DRAIN. Otherwise go to FETCH.
- DRAIN:
  - imem_req=0. Wait for imem_rvalid, discard the data, go to FETCH.
  - exc_en again in DRAIN updates pc_out and stays in DRAIN.
- imem_rvalid outside FETCH/DRAIN is ignored (protocol violation; no state change).
- exc_en and handoff in the same cycle: exc_en wins; the instruction is not considered accepted.

Test Plan:
1. Reset then imem with 2-cycle latency, instructions A,B,C, id_ready=1 -> imem_addr sequence BFC00000, BFC00004, BFC00008; if_valid pulses with if_instr=A,B,C; pc_out matches each.
2. Taken branch: ID raises is_branch, branch_pc=0x1000, during HOLD of delay slot at 0xBFC00008 with id_ready=1 -> delay slot handed off; next imem_addr=0x1000.
3. Late delay slot: is_branch, branch_pc=0x2000, id_ready=1 while in FETCH for 0xBFC0000C (latency 4) -> delay slot still delivered with pc_out=0xBFC0000C; its handoff then fetches 0x2000; target_pending cleared.
4. ID stall: id_ready=0 for 5 cycles in HOLD -> if_valid, if_instr, pc_out constant; imem_req=0; no new fetch.
5. Exception mid-fetch: exc_en, exc_pc=0xBFC00380 one cycle after request issue, latency 3 -> DRAIN; stale rdata discarded (if_valid stays 0); next request addr=0xBFC00380; a pending branch target is dropped.
6. jr to 0x1002 -> no imem_req; if_valid=1, if_addr_err=1, if_instr=0, pc_out=0x1002. Separately, reset asserted mid-FETCH -> all outputs at reset values the next cycle.
